// File: rtl/alu_result_uart_tx.sv
// Serialises each captured ALU step as a two-byte 8N1 UART frame: {HDR_TAG, op} then result.
// A one-entry pending buffer holds a step that arrives while a frame is in flight.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | line high, waiting for a step
// START   | sending start bit of the current byte
// DATA    | sending data bits, LSB first (bit_idx)
// STOP    | sending stop bit; byte_sel=1 marks the end of the frame
module alu_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [4:0]  HDR_TAG      = 5'b10100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_valid,
  input  logic [2:0] op,
  input  logic [7:0] result,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        byte_sel_q, byte_sel_d;
  logic [2:0]  cur_op_q, cur_op_d;
  logic [7:0]  cur_res_q, cur_res_d;
  logic        pend_full_q, pend_full_d;
  logic [2:0]  pend_op_q, pend_op_d;
  logic [7:0]  pend_res_q, pend_res_d;
  logic        overrun_q, overrun_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  logic        bit_done;
  logic        frame_end;
  logic [7:0]  cur_byte;

  assign bit_done  = (baud_q == BAUD_LAST);
  assign frame_end = (state_q == S_STOP) && bit_done && byte_sel_q;
  assign cur_byte  = byte_sel_q ? cur_res_q : {HDR_TAG, cur_op_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      byte_sel_q  <= 1'b0;
      cur_op_q    <= '0;
      cur_res_q   <= '0;
      pend_full_q <= 1'b0;
      pend_op_q   <= '0;
      pend_res_q  <= '0;
      overrun_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      byte_sel_q  <= byte_sel_d;
      cur_op_q    <= cur_op_d;
      cur_res_q   <= cur_res_d;
      pend_full_q <= pend_full_d;
      pend_op_q   <= pend_op_d;
      pend_res_q  <= pend_res_d;
      overrun_q   <= overrun_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    byte_sel_d  = byte_sel_q;
    cur_op_d    = cur_op_q;
    cur_res_d   = cur_res_q;
    pend_full_d = pend_full_q;
    pend_op_d   = pend_op_q;
    pend_res_d  = pend_res_q;
    overrun_d   = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (step_valid) begin
          state_d    = S_START;
          cur_op_d   = op;
          cur_res_d  = result;
          baud_d     = '0;
          bit_idx_d  = '0;
          byte_sel_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          baud_d    = '0;
          bit_idx_d = '0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = S_START;
          end else if (pend_full_q) begin
            // Frame end with a queued step: start it with no idle bit.
            byte_sel_d  = 1'b0;
            state_d     = S_START;
            cur_op_d    = pend_op_q;
            cur_res_d   = pend_res_q;
            pend_full_d = 1'b0;
          end else if (step_valid) begin
            byte_sel_d = 1'b0;
            state_d    = S_START;
            cur_op_d   = op;
            cur_res_d  = result;
          end else begin
            byte_sel_d = 1'b0;
            state_d    = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A step at frame end with an empty buffer goes straight to the shifter above.
    if (step_valid && (state_q != S_IDLE) && !(frame_end && !pend_full_q)) begin
      if (pend_full_q && !frame_end) overrun_d = 1'b1;
      pend_full_d = 1'b1;
      pend_op_d   = op;
      pend_res_d  = result;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_idx_q];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE) || pend_full_q;
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: frame-level reference model feeds a scoreboard,
// a UART monitor decodes tx and checks content and start timing.
`timescale 1ns/1ps

module tb_alu_result_uart_tx;

  localparam int CPB      = 4;
  localparam int FRAME    = 20 * CPB;
  localparam int SLOW_CPB = 868;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_valid = 1'b0;
  logic       step2 = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] result = 8'd0;
  logic       tx, busy, overrun;
  logic       tx2, busy2, overrun2;

  alu_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .step_valid(step_valid), .op(op), .result(result),
    .tx(tx), .busy(busy), .overrun(overrun)
  );

  alu_result_uart_tx dut_slow (
    .clk(clk), .rst_n(rst_n), .step_valid(step2), .op(op), .result(result),
    .tx(tx2), .busy(busy2), .overrun(overrun2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] res;
    int         start;
  } frame_t;

  frame_t sbq[$];

  bit         m_active = 0;
  int         m_end = 0;
  bit         m_pv = 0;
  logic [2:0] m_pop = 3'd0;
  logic [7:0] m_pres = 8'd0;
  bit         m_ov = 0;
  bit         mon_en = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] exp_bits(input logic [2:0] o, input logic [7:0] r);
    return {1'b1, r, 1'b0, 1'b1, {5'b10100, o}, 1'b0};
  endfunction

  task automatic m_start(input logic [2:0] o, input logic [7:0] r, input int e);
    frame_t f;
    f.op = o; f.res = r; f.start = e;
    sbq.push_back(f);
    m_end = e + FRAME;
    m_active = 1;
  endtask

  // Frame-level model: a frame occupies FRAME edges; one holding slot behind it.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_active = 0; m_pv = 0; m_ov = 0;
    end else begin
      if (m_active && cyc == m_end) begin
        if (m_pv) begin
          m_pv = 0;
          m_start(m_pop, m_pres, cyc);
        end else begin
          m_active = 0;
        end
      end
      if (step_valid) begin
        if (!m_active) m_start(op, result, cyc);
        else begin
          if (m_pv) m_ov = 1;
          m_pop = op; m_pres = result; m_pv = 1;
        end
      end
    end
  end

  logic [FRAME-1:0] mon_s;
  logic [19:0]      mon_bits;
  int               mon_t0;
  bit               mon_ab;
  frame_t           mon_f;

  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n && tx === 1'b0) begin
      mon_t0 = cyc;
      mon_ab = 0;
      mon_s[0] = tx;
      for (int i = 1; i < FRAME; i++) begin
        @(negedge clk);
        if (!mon_en) begin mon_ab = 1; break; end
        mon_s[i] = tx;
      end
      if (!mon_ab) begin
        for (int k = 0; k < 20; k++) mon_bits[k] = mon_s[k*CPB + CPB/2];
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame: got bits 0x%0h at edge %0d, expected no frame", mon_bits, mon_t0);
        end else begin
          mon_f = sbq.pop_front();
          check("frame_bits", 32'(mon_bits), 32'(exp_bits(mon_f.op, mon_f.res)));
          check("frame_start_edge", mon_t0, mon_f.start + 1);
        end
      end
    end
  end

  task automatic pulse(input logic [2:0] o, input logic [7:0] r);
    step_valid = 1'b1; op = o; result = r;
    @(negedge clk);
    step_valid = 1'b0; op = 3'($urandom); result = 8'($urandom);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sbq.size() != 0 || busy !== 1'b0) && n < 30000) begin
      @(negedge clk); n++;
    end
    check({name, "_drain_in_time"}, 32'(n < 30000), 32'd1);
    repeat (FRAME + 4) @(negedge clk);
    check({name, "_queue_empty"}, sbq.size(), 0);
    check({name, "_idle_tx"}, 32'(tx), 32'd1);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_overrun"}, 32'(overrun), 32'(m_ov));
  endtask

  task automatic idle_watch(input string name, input int cycles);
    int errs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) errs++;
    end
    check(name, errs, 0);
  endtask

  task automatic sync_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sbq.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int n, cnt, lowlen;
    bit inlow;
    int gap;

    // Reset idle
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    idle_watch("idle_after_reset", 100);

    // Single frame, busy high for exactly one frame
    pulse(3'd3, 8'h5A);
    n = 0;
    while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("single_busy_rise", 32'(busy), 32'd1);
    check("single_tx_low_with_busy", 32'(tx), 32'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin @(negedge clk); cnt++; end
    check("single_busy_len", cnt, FRAME);
    drain("single");

    // Back-to-back: second step 10 cycles into frame 1
    pulse(3'd1, 8'h11);
    repeat (9) @(negedge clk);
    pulse(3'd4, 8'hF0);
    drain("b2b");
    check("b2b_overrun_clear", 32'(overrun), 32'd0);

    // Overrun: three steps within one frame
    pulse(3'd0, 8'h81);
    repeat (5) @(negedge clk);
    pulse(3'd1, 8'h42);
    repeat (5) @(negedge clk);
    pulse(3'd2, 8'h24);
    drain("overrun");
    check("overrun_set", 32'(overrun), 32'd1);
    repeat (20) @(negedge clk);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Frame-end collision: pending full, new step on the frame-end edge
    sync_reset();
    repeat (2) @(negedge clk);
    pulse(3'd6, 8'hC3);
    repeat (4) @(negedge clk);
    pulse(3'd7, 8'h3C);
    repeat (74) @(negedge clk);
    pulse(3'd5, 8'h01);
    drain("collision");
    check("collision_no_overrun", 32'(overrun), 32'd0);

    // Frame-end with empty buffer: new step starts with no gap
    pulse(3'd2, 8'h99);
    repeat (79) @(negedge clk);
    pulse(3'd5, 8'h66);
    drain("end_direct");
    check("end_direct_no_overrun", 32'(overrun), 32'd0);

    // Randomized steps
    for (int i = 0; i < 40; i++) begin
      pulse(3'($urandom), 8'($urandom));
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 100) : $urandom_range(0, 40);
      repeat (gap) @(negedge clk);
    end
    drain("random");

    // Async reset during byte0 data bit 3
    sync_reset();
    repeat (2) @(negedge clk);
    pulse(3'd3, 8'h5A);
    repeat (18) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_busy", 32'(busy), 32'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
    sbq.delete();
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle_watch("idle_after_async_reset", 100);
    check("no_residual_frames", sbq.size(), 0);

    // Default baud instance
    step2 = 1'b1; op = 3'd3; result = 8'hA5;
    @(negedge clk);
    step2 = 1'b0;
    n = 0;
    while (busy2 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("slow_busy_rise", 32'(busy2), 32'd1);
    n = 0; lowlen = 0; inlow = 1;
    while (busy2 === 1'b1 && n < 20000) begin
      if (inlow && tx2 === 1'b0) lowlen++;
      else inlow = 0;
      n++;
      @(negedge clk);
    end
    check("slow_start_bit_len", lowlen, SLOW_CPB);
    check("slow_frame_len", n, 20 * SLOW_CPB);
    check("slow_idle_tx", 32'(tx2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
- Downstream consumer of the automatic-cycling 8-bit ALU result.
- On each operation step it captures the ALU operation code and 8-bit result, then serialises them as a two-byte 8N1 UART frame for an external terminal or logic analyser.
- Contains a one-entry holding buffer, so a step that arrives while a frame is in flight is not lost.
- Sits between the ALU core and a spare output pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
- HDR_TAG, 5'b10100, upper 5 bits of the header byte.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- step_valid  input  1  single-cycle strobe; op and result are valid this cycle.
- op  input  3  ALU operation code (0..5).
- result  input  8  ALU result.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a frame is being sent or the pending buffer is occupied.
- overrun  output  1  sticky flag: a pending step was overwritten.

Behaviour:
- Clock and reset: single clock, clk. rst_n is asynchronous and active-low.
- Reset values: tx=1, busy=0, overrun=0, state=IDLE, pending empty, baud counter=0, bit index=0, byte select=0.
- Frame format:
  - byte0 = {HDR_TAG, op}; byte1 = result.
  - Each byte is 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
  - byte1's start bit follows byte0's stop bit with no gap.
  - Frame length is 20*CLKS_PER_BIT cycles.
- States: IDLE, START, DATA, STOP.
  - The baud counter counts 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles.
  - IDLE -> START when a step is available.
  - START -> DATA after one bit period.
  - DATA -> STOP after bit index 7 completes.
  - STOP -> START for byte1 when byte select=0.
  - STOP -> frame end when byte select=1.
- Frame end:
  - If pending is full, load the pending entry and go to START next cycle. No idle bit between frames.
  - Otherwise go to IDLE.
- Latency and outputs:
  - step_valid sampled high in IDLE at edge N: {op,result} is latched at edge N and tx=0 from edge N+1.
  - tx is driven from a flop; no combinational path from inputs to tx.
  - busy=1 from edge N+1 until the edge after the final stop bit of the last frame, when pending is empty.
- Buffering, when step_valid=1 while not IDLE:
  - If pending is empty, the step is stored in pending.
  - If pending is full and is not being drained this cycle, pending is overwritten with the new step and overrun is set.
  - If step_valid coincides with the frame-end cycle, pending (if full) is drained into the shifter and the new step enters pending. No overrun in that case.
  - If step_valid coincides with frame end and pending is empty, the new step starts immediately with no idle gap.
- Capture: op and result are captured only on step_valid. Later changes to the inputs do not alter a frame in progress.
- op values 6 and 7 are transmitted unmodified; there is no range check.
- overrun clears only on reset.
- Reset mid-frame: tx returns to 1 immediately (asynchronous), the frame is aborted, and pending is discarded. No partial byte resumes after reset.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset idle: hold rst_n=0, then release with step_valid=0 for 100 cycles -> tx=1, busy=0, overrun=0 throughout.
- Single frame: step_valid pulse with op=3, result=8'h5A -> tx bits per 4-cycle period are 0,1,1,0,0,0,1,0,1,1 (byte 8'hA3), then 0,0,1,0,1,1,0,1,0,1 (byte 8'h5A). busy falls 80 cycles after tx first goes low; tx=1 thereafter.
- Back-to-back: second pulse op=4, result=8'hF0 issued 10 cycles into frame 1 -> frame 2 (8'hA4, 8'hF0) starts on the cycle after frame 1's stop bit ends, no idle bit; overrun=0.
- Overrun: three pulses (op=0/1/2) within frame 1 -> only frames for op=0 and op=2 are sent; overrun=1 and stays 1.
- Frame-end collision: pending full, and a pulse with op=5, result=8'h01 lands exactly on frame-end cycle -> pending frame is sent next, then op=5 frame; overrun stays 0.
- Async reset mid-frame: assert rst_n=0 during byte0 data bit 3 -> tx=1 within the same cycle (no clock edge needed), busy=0; after release, no residual transmission.
- Default baud: CLKS_PER_BIT=868 single frame -> start bit low for exactly 868 cycles; total frame 17360 cycles.
